sc_reg_deserializer: RTL and testbench

Serial-in, parallel-out receiver: the receiving end of the team's parallel-load shift-register transmitter. It collects a framed serial bit stream, either MSB-first or LSB-first, into a DATAWIDTH-bit word. The finished word is handed to downstream logic through a valid/acknowledge handshake. It sits between a serial link or bit-banged peripheral and the parallel datapath.

---
 rtl/sc_reg_deserializer_pkg.sv | 23 ++
 rtl/sc_reg_deserializer_bit_counter.sv | 35 +++
 rtl/sc_reg_deserializer.sv | 201 ++++++++++++++++++++
 tb/tb_sc_reg_deserializer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sc_reg_deserializer_pkg.sv
// Shared definitions for the serial-in, parallel-out receiver.
// Holds the FSM state encoding and the direction codes that are sampled
// together with the frame-start strobe.
// Optional feature macro used by the design: RegDESERIALIZER_PARITY_EN.
package sc_regdeserializer_pkg;

    // Receiver FSM states; PARITY is only reachable with RegDESERIALIZER_PARITY_EN.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } sc_regdeserializer_state_e;

    // Direction codes carried on shiftselection when start is asserted.
    localparam logic [1:0] SHIFT_MSBFIRST = 2'b01;
    localparam logic [1:0] SHIFT_LSBFIRST = 2'b10;

    // True for the two legal direction codes; 00 and 11 are rejected.
    function automatic logic sel_is_valid(input logic [1:0] sel);
        return (sel == SHIFT_MSBFIRST) || (sel == SHIFT_LSBFIRST);
    endfunction

endpackage

// File: rtl/sc_reg_deserializer_bit_counter.sv
// Parameterised up-counter with synchronous clear and count enable.
// o_tc flags the enabled edge on which the count reaches TERMINAL, so the
// caller can act on the last bit in the same cycle it is sampled.
// Optional feature macro used by the design: RegDESERIALIZER_PARITY_EN
// (this block itself is feature independent).
module sc_bit_counter #(
    parameter int TERMINAL = 8,
    parameter int CW       = $clog2(TERMINAL + 1)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [CW-1:0] r_count;

    // Count enabled strobes; clear wins over enable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Terminal count is reached on this edge when the current strobe is the last one.
    always_comb begin
        o_tc = i_en && !i_clr && (r_count == CW'(TERMINAL - 1));
    end

endmodule

// File: rtl/sc_reg_deserializer.sv
// Serial-in, parallel-out receiver for the parallel-load shift-register
// transmitter. Collects a framed bit stream (MSB-first or LSB-first) into a
// DATAWIDTH-bit word and offers it downstream with valid / active-low ack.
//
// Handshake: a word is offered while valid=1 and is consumed on any rising
// edge where valid=1 and ack_InLow=0; the data bus is stable while valid=1
// except when a new frame completes on the same edge as the ack.
//
// Optional feature macro: RegDESERIALIZER_PARITY_EN. When defined, an even
// parity bit follows the data bits and its check result is reported on
// parityerror; when undefined, parityerror is constant 0.
import sc_regdeserializer_pkg::*;

module sc_reg_deserializer #(
    parameter int RegDESERIALIZER_DATAWIDTH = 8
) (
    input  logic                                 SC_RegDESERIALIZER_CLOCK_50,
    input  logic                                 SC_RegDESERIALIZER_RESET_InLow,
    input  logic                                 SC_RegDESERIALIZER_start_InHigh,
    input  logic [1:0]                           SC_RegDESERIALIZER_shiftselection_In,
    input  logic                                 SC_RegDESERIALIZER_bitvalid_InHigh,
    input  logic                                 SC_RegDESERIALIZER_serial_In,
    input  logic                                 SC_RegDESERIALIZER_ack_InLow,
    output logic [RegDESERIALIZER_DATAWIDTH-1:0] SC_RegDESERIALIZER_data_OutBUS,
    output logic                                 SC_RegDESERIALIZER_valid_OutHigh,
    output logic                                 SC_RegDESERIALIZER_busy_OutHigh,
    output logic                                 SC_RegDESERIALIZER_overrun_OutHigh,
    output logic                                 SC_RegDESERIALIZER_parityerror_OutHigh
);

    localparam int W = RegDESERIALIZER_DATAWIDTH;

    sc_regdeserializer_state_e r_state;
    sc_regdeserializer_state_e w_state_next;

    logic [1:0]   r_dir;
    logic [W-1:0] r_shift;
    logic [W-1:0] r_data;
    logic         r_valid;
    logic         r_overrun;

    logic         w_sel_valid;
    logic         w_restart;
    logic         w_ack;
    logic         w_shift_bit;
    logic         w_tc;
    logic         w_complete;
    logic [W-1:0] w_shifted;
    logic [W-1:0] w_word;

    // Decode of the strobes that every block below depends on.
    always_comb begin
        w_sel_valid = sel_is_valid(SC_RegDESERIALIZER_shiftselection_In);
        w_restart   = SC_RegDESERIALIZER_start_InHigh && w_sel_valid;
        w_ack       = r_valid && !SC_RegDESERIALIZER_ack_InLow;
        // A data bit is taken only in SHIFT and never in a start cycle.
        w_shift_bit = (r_state == SHIFT) && SC_RegDESERIALIZER_bitvalid_InHigh &&
                      !SC_RegDESERIALIZER_start_InHigh;
        if (r_dir == SHIFT_MSBFIRST) begin
            w_shifted = {r_shift[W-2:0], SC_RegDESERIALIZER_serial_In};
        end else begin
            w_shifted = {SC_RegDESERIALIZER_serial_In, r_shift[W-1:1]};
        end
    end

    // Data-bit counter; a start strobe always rewinds it.
    sc_bit_counter #(
        .TERMINAL (W)
    ) u_bit_counter (
        .i_clk   (SC_RegDESERIALIZER_CLOCK_50),
        .i_rst_n (SC_RegDESERIALIZER_RESET_InLow),
        .i_clr   (SC_RegDESERIALIZER_start_InHigh),
        .i_en    (w_shift_bit),
        .o_tc    (w_tc)
    );

`ifdef RegDESERIALIZER_PARITY_EN
    logic w_perr_new;
    logic r_perr;

    // Frame ends on the parity strobe; the word is already complete in r_shift.
    always_comb begin
        w_complete = (r_state == PARITY) && SC_RegDESERIALIZER_bitvalid_InHigh &&
                     !SC_RegDESERIALIZER_start_InHigh;
        w_word     = r_shift;
        w_perr_new = (^r_shift) ^ SC_RegDESERIALIZER_serial_In;
    end
`else
    // Frame ends on the W-th data bit; the word includes that bit.
    always_comb begin
        w_complete = w_shift_bit && w_tc;
        w_word     = w_shifted;
    end
`endif

    // Next-state logic; a start in a busy state aborts the current frame.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_restart) begin
                    w_state_next = SHIFT;
                end
            end
            SHIFT, PARITY: begin
                if (SC_RegDESERIALIZER_start_InHigh) begin
                    // An illegal direction on a restart drops the frame entirely.
                    w_state_next = w_sel_valid ? SHIFT : IDLE;
                end else if (w_shift_bit && w_tc) begin
`ifdef RegDESERIALIZER_PARITY_EN
                    w_state_next = PARITY;
`else
                    w_state_next = IDLE;
`endif
                end else if ((r_state == PARITY) && SC_RegDESERIALIZER_bitvalid_InHigh) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge SC_RegDESERIALIZER_CLOCK_50 or negedge SC_RegDESERIALIZER_RESET_InLow) begin
        if (!SC_RegDESERIALIZER_RESET_InLow) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Shift register and latched direction; cleared/re-latched on every legal start.
    always_ff @(posedge SC_RegDESERIALIZER_CLOCK_50 or negedge SC_RegDESERIALIZER_RESET_InLow) begin
        if (!SC_RegDESERIALIZER_RESET_InLow) begin
            r_shift <= '0;
            r_dir   <= SHIFT_MSBFIRST;
        end else if (w_restart) begin
            r_shift <= '0;
            r_dir   <= SC_RegDESERIALIZER_shiftselection_In;
        end else if (w_shift_bit) begin
            r_shift <= w_shifted;
        end
    end

    // Output buffer, valid and overrun: a finished word is kept only if the
    // buffer is empty or being acknowledged on the same edge.
    always_ff @(posedge SC_RegDESERIALIZER_CLOCK_50 or negedge SC_RegDESERIALIZER_RESET_InLow) begin
        if (!SC_RegDESERIALIZER_RESET_InLow) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_complete) begin
            if (!r_valid || w_ack) begin
                r_data    <= w_word;
                r_valid   <= 1'b1;
                r_overrun <= 1'b0;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (w_ack) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

`ifdef RegDESERIALIZER_PARITY_EN
    // Parity flag follows the held word; a dropped bad word still raises it.
    always_ff @(posedge SC_RegDESERIALIZER_CLOCK_50 or negedge SC_RegDESERIALIZER_RESET_InLow) begin
        if (!SC_RegDESERIALIZER_RESET_InLow) begin
            r_perr <= 1'b0;
        end else if (w_complete) begin
            if (!r_valid || w_ack) begin
                r_perr <= w_perr_new;
            end else begin
                r_perr <= r_perr | w_perr_new;
            end
        end else if (w_ack) begin
            r_perr <= 1'b0;
        end
    end

    // Drive the parity flag from its register.
    always_comb begin
        SC_RegDESERIALIZER_parityerror_OutHigh = r_perr;
    end
`else
    // Without parity there is nothing to report.
    always_comb begin
        SC_RegDESERIALIZER_parityerror_OutHigh = 1'b0;
    end
`endif

    // Remaining outputs straight from registers.
    always_comb begin
        SC_RegDESERIALIZER_data_OutBUS     = r_data;
        SC_RegDESERIALIZER_valid_OutHigh   = r_valid;
        SC_RegDESERIALIZER_overrun_OutHigh = r_overrun;
        SC_RegDESERIALIZER_busy_OutHigh    = (r_state != IDLE);
    end

endmodule

// File: tb/tb_sc_reg_deserializer.sv
// Directed bench for sc_reg_deserializer with DATAWIDTH = 8.
// Honours RegDESERIALIZER_PARITY_EN when it is defined for the build.
module tb_sc_reg_deserializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] sel;
    logic       bitvalid;
    logic       serial;
    logic       ack_n;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       overrun;
    logic       perr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sc_reg_deserializer #(
        .RegDESERIALIZER_DATAWIDTH (8)
    ) dut (
        .SC_RegDESERIALIZER_CLOCK_50            (clk),
        .SC_RegDESERIALIZER_RESET_InLow         (rst_n),
        .SC_RegDESERIALIZER_start_InHigh        (start),
        .SC_RegDESERIALIZER_shiftselection_In   (sel),
        .SC_RegDESERIALIZER_bitvalid_InHigh     (bitvalid),
        .SC_RegDESERIALIZER_serial_In           (serial),
        .SC_RegDESERIALIZER_ack_InLow           (ack_n),
        .SC_RegDESERIALIZER_data_OutBUS         (data),
        .SC_RegDESERIALIZER_valid_OutHigh       (valid),
        .SC_RegDESERIALIZER_busy_OutHigh        (busy),
        .SC_RegDESERIALIZER_overrun_OutHigh     (overrun),
        .SC_RegDESERIALIZER_parityerror_OutHigh (perr)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] s, input logic bv, input logic sb);
        start = 1'b1; sel = s; bitvalid = bv; serial = sb;
        tick();
        start = 1'b0; bitvalid = 1'b0; serial = 1'b0;
    endtask

    task automatic send_bit(input logic b, input logic a_n);
        bitvalid = 1'b1; serial = b; ack_n = a_n;
        tick();
        bitvalid = 1'b0; serial = 1'b0; ack_n = 1'b1;
    endtask

    task automatic do_ack();
        ack_n = 1'b0;
        tick();
        ack_n = 1'b1;
    endtask

    // Sends b[7] first; ack_last pulls ack low on the frame's final strobe.
    task automatic send_frame(input logic [1:0] s, input logic [7:0] b, input logic ack_last);
        do_start(s, 1'b0, 1'b0);
`ifdef RegDESERIALIZER_PARITY_EN
        for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b1);
        send_bit(^b, ~ack_last);
`else
        for (int i = 7; i >= 1; i--) send_bit(b[i], 1'b1);
        send_bit(b[0], ~ack_last);
`endif
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sel = 2'b00; bitvalid = 1'b0; serial = 1'b0; ack_n = 1'b1;
        tick(); tick();
        total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        total++; if (perr !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b exp=0", perr); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_msb_first();
        logic [7:0] b;
        b = 8'b1011_0010;
        do_start(2'b01, 1'b0, 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL msb_busy_after_start got=%b exp=1", busy); end
        for (int i = 7; i >= 1; i--) send_bit(b[i], 1'b1);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL msb_valid_early got=%b exp=0", valid); end
        send_bit(b[0], 1'b1);
`ifdef RegDESERIALIZER_PARITY_EN
        total++; if (busy !== 1'b1 || valid !== 1'b0) begin bad++; $display("FAIL msb_wait_parity busy=%b valid=%b exp 1/0", busy, valid); end
        send_bit(1'b0, 1'b1);
`endif
        total++; if (data !== 8'hB2) begin bad++; $display("FAIL msb_data got=%h exp=b2", data); end
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL msb_valid got=%b exp=1", valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL msb_busy got=%b exp=0", busy); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL msb_overrun got=%b exp=0", overrun); end
    endtask

    task automatic test_lsb_ack();
        do_ack();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL ack1_valid got=%b exp=0", valid); end
        total++; if (data !== 8'hB2) begin bad++; $display("FAIL ack1_data_hold got=%h exp=b2", data); end
        send_frame(2'b10, 8'b1011_0010, 1'b0);
        total++; if (data !== 8'h4D || valid !== 1'b1) begin bad++; $display("FAIL lsb_data got=%h/%b exp=4d/1", data, valid); end
        do_ack();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL lsb_ack_valid got=%b exp=0", valid); end
        total++; if (data !== 8'h4D) begin bad++; $display("FAIL lsb_ack_data got=%h exp=4d", data); end
    endtask

    task automatic test_overrun();
        send_frame(2'b01, 8'h3C, 1'b0);
        send_frame(2'b01, 8'hC3, 1'b0);
        total++; if (data !== 8'h3C) begin bad++; $display("FAIL ovr_data got=%h exp=3c", data); end
        total++; if (overrun !== 1'b1 || valid !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b/%b exp=1/1", overrun, valid); end
        do_ack();
        total++; if (overrun !== 1'b0 || valid !== 1'b0) begin bad++; $display("FAIL ovr_ack got=%b/%b exp=0/0", overrun, valid); end
        total++; if (data !== 8'h3C) begin bad++; $display("FAIL ovr_ack_data got=%h exp=3c", data); end
    endtask

    task automatic test_ack_on_complete();
        send_frame(2'b01, 8'h5A, 1'b0);
        send_frame(2'b01, 8'hA5, 1'b1);
        total++; if (data !== 8'hA5) begin bad++; $display("FAIL ackc_data got=%h exp=a5", data); end
        total++; if (valid !== 1'b1 || overrun !== 1'b0) begin bad++; $display("FAIL ackc_flags got=%b/%b exp=1/0", valid, overrun); end
        do_ack();
    endtask

    task automatic test_restart();
        do_start(2'b01, 1'b1, 1'b1);
        send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1);
        do_start(2'b01, 1'b1, 1'b0);
        total++; if (busy !== 1'b1 || valid !== 1'b0) begin bad++; $display("FAIL rst_mid busy/valid got=%b/%b exp=1/0", busy, valid); end
        for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b1);
`ifdef RegDESERIALIZER_PARITY_EN
        send_bit(1'b0, 1'b1);
`endif
        total++; if (data !== 8'hFF || valid !== 1'b1) begin bad++; $display("FAIL restart_data got=%h/%b exp=ff/1", data, valid); end
        do_ack();
    endtask

    task automatic test_start_with_bit();
        do_start(2'b01, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b1);
`ifdef RegDESERIALIZER_PARITY_EN
        send_bit(1'b0, 1'b1);
`endif
        total++; if (data !== 8'h00 || valid !== 1'b1) begin bad++; $display("FAIL startbit_data got=%h/%b exp=00/1", data, valid); end
    endtask

    task automatic test_invalid_sel();
        do_start(2'b00, 1'b0, 1'b0);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL sel00_busy got=%b exp=0", busy); end
        do_start(2'b11, 1'b0, 1'b0);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL sel11_busy got=%b exp=0", busy); end
        for (int i = 0; i < 9; i++) send_bit(1'b1, 1'b1);
        total++; if (data !== 8'h00 || valid !== 1'b1 || overrun !== 1'b0) begin bad++; $display("FAIL sel_idle_bits got=%h/%b/%b exp=00/1/0", data, valid, overrun); end
    endtask

    task automatic test_reset_mid();
        do_start(2'b01, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        total++; if (data !== 8'h00 || valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || perr !== 1'b0) begin
            bad++; $display("FAIL async_reset got d=%h v=%b b=%b o=%b p=%b exp all 0", data, valid, busy, overrun, perr);
        end
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(2'b01, 8'h01, 1'b0);
        total++; if (data !== 8'h01 || valid !== 1'b1) begin bad++; $display("FAIL post_reset_data got=%h/%b exp=01/1", data, valid); end
        do_ack();
    endtask

    task automatic test_parity();
`ifdef RegDESERIALIZER_PARITY_EN
        logic [7:0] b;
        b = 8'hB2;
        do_start(2'b01, 1'b0, 1'b0);
        for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b1);
        send_bit(1'b1, 1'b1);
        total++; if (data !== 8'hB2 || valid !== 1'b1 || perr !== 1'b1) begin bad++; $display("FAIL par_bad got=%h/%b/%b exp=b2/1/1", data, valid, perr); end
        do_ack();
        total++; if (perr !== 1'b0) begin bad++; $display("FAIL par_ack got=%b exp=0", perr); end
        do_start(2'b01, 1'b0, 1'b0);
        for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b1);
        send_bit(1'b0, 1'b1);
        total++; if (valid !== 1'b1 || perr !== 1'b0) begin bad++; $display("FAIL par_good got=%b/%b exp=1/0", valid, perr); end
        do_ack();
`else
        send_frame(2'b01, 8'hB2, 1'b0);
        total++; if (perr !== 1'b0 || valid !== 1'b1) begin bad++; $display("FAIL noparity_flag got=%b/%b exp=0/1", perr, valid); end
        do_ack();
`endif
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_ack();
        test_overrun();
        test_ack_on_complete();
        test_restart();
        test_start_with_bit();
        test_invalid_sel();
        test_reset_mid();
        test_parity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
